// File: rtl/enet_nios_sram_arbiter_if.sv
// Avalon-style single-word master bus: one instance per master (CPU data, Ethernet DMA).
// Carries the master's address/strobes/data and the slave's waitrequest/readdata.
// Modports: master drives the request side; slave drives the waitrequest/readdata side.
interface enet_nios_sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/enet_nios_sram_arbiter.sv
// Round-robin arbiter and cycle sequencer for the shared async board SRAM (CPU vs Ethernet DMA).
// Latency: strobes active for WAIT_STATES+1 cycles after the grant edge; waitrequest low WAIT_STATES+2 cycles after.
// Backpressure: each master stalls on waitrequest, which drops for exactly one cycle when its transfer completes.
//
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   cpu, dma             Avalon-style slave ports (address/read/write/writedata/byteenable in,
//                        waitrequest/readdata out); readdata of both comes from one shared register
//   sram_addr/wdata/be_n registered SRAM address, write data and active-low byte lanes
//   sram_cs_n/oe_n/we_n  registered active-low SRAM strobes
//   sram_rdata           SRAM read data, captured at the last ACCESS edge
module enet_nios_sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  enet_nios_sram_arbiter_if.slave cpu,
  enet_nios_sram_arbiter_if.slave dma,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic                sram_cs_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_e;

  state_e              state;
  logic [3:0]          ws_cnt;
  grant_e              last_grant;  // also the owner of the transfer in flight
  logic                is_write;
  logic [DATA_W-1:0]   rd_q;
  logic                cpu_wait_q;
  logic                dma_wait_q;

  // Request decode and the mux of the master that would win this cycle.
  logic                cpu_req;
  logic                dma_req;
  logic                pick_dma;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

  always_comb begin
    cpu_req   = cpu.read | cpu.write;
    dma_req   = dma.read | dma.write;
    // DMA wins when it is the only requester, or on a tie when the CPU went last.
    pick_dma  = dma_req & (~cpu_req | (last_grant == GNT_CPU));
    // read and write together is treated as a write.
    sel_write = pick_dma ? dma.write      : cpu.write;
    sel_addr  = pick_dma ? dma.address    : cpu.address;
    sel_wdata = pick_dma ? dma.writedata  : cpu.writedata;
    sel_be    = pick_dma ? dma.byteenable : cpu.byteenable;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ws_cnt     <= 4'd0;
      last_grant <= GNT_DMA;  // CPU wins the first tie
      is_write   <= 1'b0;
      rd_q       <= '0;
      cpu_wait_q <= 1'b1;
      dma_wait_q <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be_n  <= '1;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req || dma_req) begin
            sram_addr  <= sel_addr;
            sram_wdata <= sel_wdata;
            sram_be_n  <= ~sel_be;
            sram_cs_n  <= 1'b0;
            sram_oe_n  <= sel_write;
            sram_we_n  <= ~sel_write;
            is_write   <= sel_write;
            ws_cnt     <= 4'(WAIT_STATES);
            last_grant <= pick_dma ? GNT_DMA : GNT_CPU;
            state      <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (ws_cnt != 4'd0) begin
            ws_cnt <= ws_cnt - 4'd1;
          end else begin
            // Last strobe cycle: data is valid at this edge for reads.
            if (!is_write) begin
              rd_q <= sram_rdata;
            end
            sram_cs_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            // waitrequest is registered, so it is low during DONE.
            if (last_grant == GNT_DMA) begin
              dma_wait_q <= 1'b0;
            end else begin
              cpu_wait_q <= 1'b0;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Always return through IDLE: gives the forced idle cycle and lets the
          // master drop its request before the next arbitration.
          cpu_wait_q <= 1'b1;
          dma_wait_q <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          cpu_wait_q <= 1'b1;
          dma_wait_q <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu.waitrequest = cpu_wait_q;
  assign dma.waitrequest = dma_wait_q;
  assign cpu.readdata    = rd_q;
  assign dma.readdata    = rd_q;

endmodule

// File: doc/enet_nios_sram_arbiter.md
# enet_nios_sram_arbiter

Two-master arbiter and cycle sequencer for the shared asynchronous board SRAM in the enet_nios system. It accepts Avalon-style single-word transfers from the Nios CPU data master and from the Ethernet DMA master. It grants one master at a time using round-robin priority and drives the SRAM control strobes through a programmable number of wait states. It returns read data to the granted master with a `waitrequest` handshake.

## Interface
- `ADDR_W`, 18, word address width
- `DATA_W`, 16, data width; must be a multiple of 8
- `WAIT_STATES`, 2, extra SRAM access cycles; legal range 0..15
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`
- `cpu_address` / `dma_address`  in  ADDR_W  master word address
- `cpu_read` / `dma_read`  in  1  read request
- `cpu_write` / `dma_write`  in  1  write request
- `cpu_writedata` / `dma_writedata`  in  DATA_W  write data
- `cpu_byteenable` / `dma_byteenable`  in  DATA_W/8  byte lanes, active high
- `cpu_waitrequest` / `dma_waitrequest`  out  1  stall; low for exactly one cycle when the transfer completes
- `cpu_readdata` / `dma_readdata`  out  DATA_W  both driven from one shared read register
- `sram_addr`  out  ADDR_W  registered
- `sram_wdata`  out  DATA_W  registered
- `sram_be_n`  out  DATA_W/8  registered, active low
- `sram_cs_n`, `sram_oe_n`, `sram_we_n`  out  1  registered strobes, active low
- `sram_rdata`  in  DATA_W  SRAM read data

## Operation
- States: IDLE, ACCESS, DONE. A 4-bit counter `ws_cnt` times the ACCESS state.
- A master requests when its `read` or `write` is high. If both are high, the transfer is a write.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both request: grant the master that is not `last_grant`.
  - On grant: load address, write data and `~byteenable` into the SRAM registers. Assert `sram_cs_n=0`. Reads assert `sram_oe_n=0`; writes assert `sram_we_n=0`. Set `ws_cnt=WAIT_STATES`, update `last_grant`, go to ACCESS.
- ACCESS:
  - If `ws_cnt!=0`: decrement and stay in ACCESS.
  - If `ws_cnt==0`: for a read, capture `sram_rdata` into the read register. Deassert `cs_n`, `oe_n` and `we_n` (all to 1). Go to DONE.
- DONE: drive the granted master's `waitrequest` low; the other master's stays high. Go to IDLE unconditionally. The master drops its request after seeing `waitrequest` low.
- `sram_addr`, `sram_wdata` and `sram_be_n` hold from grant until the next grant.
- The read register holds its value until the next read capture.
- `waitrequest` is high in every cycle except the owning master's DONE cycle, whether or not that master is requesting.
- A master changing its request or address while stalled is illegal. The arbiter ignores the change until the next IDLE.

## Timing
- Reset (synchronous, `reset_n=0` at an edge):
  - state=IDLE, `ws_cnt=0`, `last_grant=DMA` (so the CPU wins the first tie).
  - `sram_cs_n=sram_oe_n=sram_we_n=1`, `sram_be_n` all 1, `sram_addr=0`, `sram_wdata=0`.
  - Read register = 0; both `waitrequest=1`.
- Reset mid-transfer: the outputs above take their reset values at that edge, the transfer is dropped without completing, and masters must reissue.
- Latency: the request is sampled in IDLE at edge 0. The strobes are active after edge 0 for `WAIT_STATES+1` cycles. DONE, with `waitrequest` low, is the cycle after edge `WAIT_STATES+1`. The next grant is no earlier than edge `WAIT_STATES+3`.
- Read data sampled by the master while `waitrequest` is low equals `sram_rdata` at edge `WAIT_STATES+1`.
- One forced idle cycle between transfers. Sustained throughput is one transfer per `WAIT_STATES+3` cycles.
- Continuous contention alternates strictly CPU, DMA, CPU, ..., so neither master waits longer than one other transfer.
- With `WAIT_STATES=0`, ACCESS lasts exactly one cycle.

## Test plan
- Reset then idle: after the `reset_n` pulse, all SRAM strobes are 1, `sram_addr=0`, and both `waitrequest=1` for 20 cycles.
- CPU read with `WAIT_STATES=2`, address `0x00123`, SRAM model returns `0xBEEF`:
  - `cs_n` and `oe_n` are low for 3 cycles.
  - `cpu_waitrequest` is low in cycle 4 with `cpu_readdata=0xBEEF`.
  - `dma_waitrequest` stays 1.
- DMA write `0xA55A` to `0x3FFFF` with `byteenable=2'b10`:
  - `we_n` is low for `WAIT_STATES+1` cycles with `sram_be_n=2'b01`.
  - The model memory shows only the upper byte changed.
- Simultaneous CPU and DMA read requests held for 6 transfers:
  - Grant order is CPU, DMA, CPU, DMA, CPU, DMA.
  - Each `waitrequest` low pulse is exactly one cycle wide.
- Both `read` and `write` high on the CPU: a write is performed (`we_n` low, `oe_n` high).
- `reset_n` asserted during the second ACCESS cycle of a DMA write:
  - Strobes return to 1 on that edge, and `dma_waitrequest` never pulses low.
  - A subsequent CPU read completes normally with latency `WAIT_STATES+2`.
